alu_result_select_pipe: RTL and testbench
=========================================

# alu_result_select_pipe

Parametrised, registered result selector for the ALU output stage. Picks one of `NUM_IN` operation results by opcode select and holds it in a single pipeline register behind a valid/ready handshake. Sits between the per-operation units (add, sub, and, or, sll, sra, and any later additions) and the writeback path. Select codes at or above `NUM_IN` drive zero and raise an illegal flag.

## Interface

Parameters:
- `WIDTH`, 32: width of each result and of `out_data`.
- `NUM_IN`, 6: number of selectable inputs, 2..16.
- `SEL_W`, 3: select width; must satisfy 2^`SEL_W` >= `NUM_IN`.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_data`  in  `NUM_IN*WIDTH`  flattened results; input i occupies bits [i*WIDTH +: WIDTH].
- `in_sel`  in  `SEL_W`  select code; value i picks input i.
- `in_valid`  in  1  upstream offers `in_data`/`in_sel` this cycle.
- `in_ready`  out  1  block can accept this cycle.
- `flush`  in  1  discards the held result.
- `out_data`  out  `WIDTH`  registered selected result.
- `out_illegal`  out  1  registered; the held result came from an out-of-range select.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `illegal_count`  out  8  saturating count of accepted illegal selects; reads 0 without `ALU_SEL_ILLEGAL_CNT_EN`.

## Operation

- Combinational selection: `in_sel` < `NUM_IN` selects `in_data` slice `in_sel`. Otherwise the selected value is all-zero and illegal = 1.
- `in_ready` = `!flush && (!out_valid || out_ready)`. This is combinational and gives full throughput: one transfer per cycle when downstream is ready.
- Accept occurs when `in_valid && in_ready`. On accept, `out_data`, `out_illegal` and `out_valid` = 1 load at the next edge.
- Drain occurs when `out_valid && out_ready` with no accept in the same cycle. At the next edge, `out_valid` = 0. `out_data` and `out_illegal` hold their last values and are don't-care while invalid.
- The two-state view is EMPTY (`out_valid`=0) and FULL (`out_valid`=1):
  - EMPTY to FULL on accept.
  - FULL to FULL on accept together with drain (replace).
  - FULL to EMPTY on drain without accept, or on flush.
  - FULL holds when `out_ready`=0. `out_data` and `out_illegal` must remain stable while FULL and stalled.
- Flush has priority. `in_ready` is 0 during flush, so no accept occurs. `out_valid` clears at the next edge regardless of `out_ready`. A downstream handshake completing in the flush cycle still counts as delivered.
- `illegal_count` (macro enabled) increments by 1 on each accept with illegal = 1. It saturates at 255 and is unaffected by flush.

## Timing

- Latency is 1 cycle from accept to `out_valid`.
- Reset (`reset_n`=0 at an edge):
  - `out_valid`=0, `out_data`=0, `out_illegal`=0, `illegal_count`=0.
  - `in_ready` reads 0 while `reset_n`=0. Reset overrides any accept, drain or flush in that cycle.
- Reset mid-stall drops the held result with no output handshake.
- `out_*` come straight from flops. `in_ready` is the only combinational output; it depends on `flush`, `out_valid` and `out_ready`.

## Configuration

- Macro: `ALU_SEL_ILLEGAL_CNT_EN`.
- Defined: the 8-bit saturating counter is built and drives `illegal_count`.
- Undefined: no counter flops are built, `illegal_count` is tied to 0, and all other behaviour is identical.

## Test plan

- Reset, then default params, `out_ready`=1. Present `in_sel`=0..5 back-to-back with inputs 0x11111111·(i+1). Expect one cycle of latency, `out_valid` high for 6 consecutive cycles, data matching each slice, and `out_illegal`=0.
- `in_sel`=6 and then `in_sel`=7. Expect `out_data`=0 and `out_illegal`=1. With the macro defined, expect `illegal_count`=2; undefined, 0.
- Backpressure: accept sel=2 (0xDEADBEEF), then hold `out_ready`=0 for 4 cycles while `in_valid`=1 with sel=3. Expect `in_ready`=0, `out_data` stable at 0xDEADBEEF, and sel=3's data appearing one cycle after `out_ready` rises.
- Flush while FULL and stalled with `in_valid`=1. Expect `in_ready`=0 that cycle, `out_valid`=0 next cycle, and no accept. The next accept proceeds normally.
- Drive `reset_n`=0 while FULL. Expect all outputs zero after the edge and `in_ready`=0 during reset. Accept resumes the cycle after `reset_n`=1.
- With the macro defined, perform 300 illegal accepts. Expect `illegal_count` to saturate at 255.

Source files
------------

// File: rtl/alu_result_select_pipe.sv
// Registered ALU result selector: picks one of NUM_IN results by select code behind a
// single-entry valid/ready stage. Optional macro ALU_SEL_ILLEGAL_CNT_EN adds an 8-bit
// saturating counter of accepted illegal selects.
module alu_result_select_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 6,
  parameter int SEL_W  = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_illegal,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              illegal_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sel_data;
  logic             sel_illegal;
  logic             accept;
  logic [WIDTH-1:0] data_q;
  logic             illegal_q;

  // Select codes at or above NUM_IN fall through to zero data with the illegal flag.
  always_comb begin
    sel_data    = {WIDTH{1'b0}};
    sel_illegal = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_illegal = 1'b0;
      end else begin
        sel_data    = sel_data;
        sel_illegal = sel_illegal;
      end
    end
  end

  // Upstream handshake; held low during reset and flush.
  always_comb begin
    in_ready = reset_n && !flush && ((state == EMPTY) || out_ready);
    accept   = in_valid && in_ready;
  end

  // State register for the EMPTY/FULL stage.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush wins, then accept (load or replace), then drain.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
        end else begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (flush) begin
          state_next = EMPTY;
        end else if (accept) begin
          state_next = FULL;
        end else if (out_ready) begin
          state_next = EMPTY;
        end else begin
          state_next = FULL;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Output decode of the stage state.
  always_comb begin
    out_valid = (state == FULL);
  end

  // Payload register loads only on accept, so it stays stable through stalls.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q    <= {WIDTH{1'b0}};
      illegal_q <= 1'b0;
    end else if (accept) begin
      data_q    <= sel_data;
      illegal_q <= sel_illegal;
    end else begin
      data_q    <= data_q;
      illegal_q <= illegal_q;
    end
  end

  assign out_data    = data_q;
  assign out_illegal = illegal_q;

`ifdef ALU_SEL_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt;

  // Saturating count of accepted illegal selects; flush does not touch it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      illegal_cnt <= 8'h00;
    end else if (accept && sel_illegal && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'h01;
    end else begin
      illegal_cnt <= illegal_cnt;
    end
  end

  assign illegal_count = illegal_cnt;
`else
  assign illegal_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Directed self-checking bench for alu_result_select_pipe with default parameters.
module tb_alu_result_select_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 6;
  localparam int SEL_W  = 3;

`ifdef ALU_SEL_ILLEGAL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                    clock;
  logic                    reset_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_illegal;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              illegal_count;

  int errors = 0;
  int checks = 0;

  alu_result_select_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_data     (out_data),
    .out_illegal  (out_illegal),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .illegal_count(illegal_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < NUM_IN; i++) begin
      in_data[i*WIDTH +: WIDTH] = 32'h11111111 * (i + 1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_sel = 3'd1; flush = 1'b0; out_ready = 1'b1;
    load_pattern();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
    checks++; if (illegal_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", illegal_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_select();
    logic [WIDTH-1:0] exp;
    out_ready = 1'b1;
    load_pattern();
    in_valid = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      in_sel = SEL_W'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sel%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
      exp = 32'h11111111 * (i + 1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel%0d_valid: got %b want 1", i, out_valid); end
      checks++; if (out_data !== exp) begin errors++; $display("FAIL sel%0d_data: got %h want %h", i, out_data, exp); end
      checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL sel%0d_illegal: got %b want 0", i, out_illegal); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int s = 6; s <= 7; s++) begin
      in_sel = SEL_W'(s);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill%0d_valid: got %b want 1", s, out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL ill%0d_data: got %h want 0", s, out_data); end
      checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill%0d_flag: got %b want 1", s, out_illegal); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (illegal_count !== (CNT_EN ? 8'd2 : 8'd0)) begin
      errors++; $display("FAIL ill_count: got %0d want %0d", illegal_count, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_backpressure();
    in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    in_data[3*WIDTH +: WIDTH] = 32'hCAFEF00D;
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd2;
    tick();
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_first: got %h want deadbeef", out_data); end
    out_ready = 1'b0; in_sel = 3'd3;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", c, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", c, out_valid); end
      checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold%0d: got %h want deadbeef", c, out_data); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_data !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_next: got %h want cafef00d", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    load_pattern();
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd4;
    tick();
    checks++; if (out_data !== 32'h55555555) begin errors++; $display("FAIL fl_load: got %h want 55555555", out_data); end
    out_ready = 1'b0; in_sel = 3'd5; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", out_valid); end
    flush = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_resume_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h66666666) begin errors++; $display("FAIL fl_resume_data: got %h want 66666666", out_data); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd7;
    tick();
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL rs_load_illegal: got %b want 1", out_illegal); end
    out_ready = 1'b0; in_sel = 3'd0; reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_in_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b want 0", out_valid); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL rs_illegal: got %b want 0", out_illegal); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rs_data: got %h want 0", out_data); end
    checks++; if (illegal_count !== 8'd0) begin errors++; $display("FAIL rs_count: got %0d want 0", illegal_count); end
    reset_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rs_resume_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h11111111) begin errors++; $display("FAIL rs_resume_data: got %h want 11111111", out_data); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd6;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (n == 99) begin
        checks++;
        if (illegal_count !== (CNT_EN ? 8'd100 : 8'd0)) begin
          errors++; $display("FAIL sat_mid: got %0d want %0d", illegal_count, CNT_EN ? 100 : 0);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (illegal_count !== (CNT_EN ? 8'd255 : 8'd0)) begin
      errors++; $display("FAIL sat_final: got %0d want %0d", illegal_count, CNT_EN ? 255 : 0);
    end
  endtask

  initial begin
    in_data = '0;
    test_reset();
    test_select();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_midstall();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
